wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master to one-slave Wishbone (classic, non-pipelined) arbiter with round-robin grant and a per-transaction timeout.
- Lets the core instruction bus (m0) and the second-memory/data bus (m1) share a single Controller memory port.
- Also returns a bus error when the slave never acknowledges, so a hung access cannot stall the core indefinitely.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; SEL width = DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, cycles of s_stb_o without s_ack_i before error; 0 disables timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle/strobe/write
- m0_sel_i  in  DATA_WIDTH/8  master 0 byte selects
- m0_addr_i  in  ADDR_WIDTH  master 0 address
- m0_data_i  in  DATA_WIDTH  master 0 write data
- m0_data_o  out  DATA_WIDTH  master 0 read data
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge/error
- m1_*  same set as m0, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle/strobe/write
- s_sel_o  out  DATA_WIDTH/8  slave byte selects
- s_addr_o  out  ADDR_WIDTH  slave address
- s_data_o  out  DATA_WIDTH  slave write data
- s_data_i  in  DATA_WIDTH  slave read data
- s_ack_i  in  1  slave acknowledge
- grant_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1), for debug

Behaviour:
- Reset (async, rst=1): state IDLE; grant_o=0; last_grant=m1, so m0 wins the first tie; timeout counter=0.
- All outputs are 0 under reset. s_cyc_o drops immediately, without waiting for a clock edge.
- States:
  - IDLE: no master granted.
  - GRANT0 / GRANT1: one master owns the bus.
  - ERR: error being signalled to the owning master.
- IDLE:
  - A request is mx_cyc_i & mx_stb_i.
  - One requester: grant it at the next edge.
  - Both requesting: grant the master that is not last_grant.
  - Grant latency: s_cyc_o rises exactly 1 cycle after the request is first seen.
- GRANTx:
  - s_cyc/stb/we/sel/addr/data_o mirror master x combinationally.
  - s_ack_i is routed combinationally to mx_ack_o; s_data_i drives both m*_data_o.
  - The non-granted master's ack_o and err_o are 0.
- Bus lock: the grant is held while mx_cyc_i=1, across any number of stb beats.
  - Release happens on the edge where mx_cyc_i=0: set last_grant=x and go to IDLE.
  - A pending request from the other master is granted on the following edge, so the turnaround costs 1 idle cycle.
- Timeout counter:
  - Increments each cycle with s_stb_o=1 and s_ack_i=0.
  - Clears on s_ack_i, on an mx_stb_i deassert, or on any state change.
  - In the cycle the counter equals TIMEOUT_CYCLES-1 with no ack: pulse mx_err_o=1 for 1 cycle (combinational with that cycle), then go to ERR.
- ERR:
  - s_cyc_o = s_stb_o = 0 for one cycle.
  - last_grant=x, then IDLE.
  - The master is expected to drop cyc. If it keeps requesting, it re-arbitrates normally.
- Simultaneous ack and timeout in the same cycle: ack wins, err is not asserted, no transition to ERR.
- Master drops cyc in the same cycle its ack arrives: the ack is still delivered and the grant is released at that edge.
- Any request with cyc=1 and stb=0 does not win arbitration from IDLE.
- TIMEOUT_CYCLES=0: counter is removed and ERR is unreachable.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Decomposition:
- Shared package wb_pkg:
  - state enum (IDLE, GRANT0, GRANT1, ERR)
  - SEL width helper
  - grant one-hot constants
- One natural sub-module: wb_rr_arbiter2.
  - Combinational round-robin pick from {req0, req1, last_grant}.
  - Reusable for future N-master versions.
- The mux and the FSM stay in the top block.

Test Plan:
1. m0 read at addr 0x0000_0100, slave acks 2 cycles after s_stb_o with s_data_i=0xDEADBEEF.
   - s_cyc_o rises 1 cycle after the request.
   - m0_ack_o=1 with m0_data_o=0xDEADBEEF.
   - m1_ack_o stays 0; grant_o=01.
2. m0 and m1 both request in the first cycle after reset.
   - m0 is granted first.
   - After m0 drops cyc: 1 idle cycle, then grant_o=10.
   - The next simultaneous tie goes to m0.
3. m0 holds cyc for 3 write beats (sel=0xF, data 0x1,0x2,0x3) while m1 requests continuously.
   - grant_o stays 01 through all three acks.
   - m1 is granted only after m0_cyc_i falls.
4. TIMEOUT_CYCLES=8, slave never acks a m1 read.
   - m1_err_o=1 on the 8th cycle of s_stb_o.
   - s_cyc_o=0 on the next cycle, then IDLE.
   - A pending m0 request is then granted.
5. TIMEOUT_CYCLES=8, s_ack_i asserted on the 8th strobe cycle.
   - m1_ack_o=1, m1_err_o=0, no ERR state.
6. rst asserted mid-transaction, between clock edges.
   - s_cyc_o, s_stb_o and grant_o go to 0 before the next edge.
   - After release, m0 wins a tie.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone two-master arbiter.
package wb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // One-hot grant encodings reported on grant_o.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Byte-select width for a given data width.
    function automatic int sel_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-requester round-robin pick: on a tie the requester that was not
// granted last wins. last_grant = 0 means m0 was last, 1 means m1 was last.
module wb_rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    // Combinational pick; at most one of gnt0/gnt1 is set.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (last_grant) gnt0 = 1'b1;
            else            gnt1 = 1'b1;
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master to one-slave classic Wishbone arbiter with round-robin grant,
// bus lock while the owner holds cyc, and a per-access ack timeout.
// Handshake: a master access is presented while cyc&stb are high and
// completes in the cycle the slave returns ack (or err on timeout).
module wb_bus_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               m0_cyc_i,
    input  logic                               m0_stb_i,
    input  logic                               m0_we_i,
    input  logic [sel_width(DATA_WIDTH)-1:0]   m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]              m0_addr_i,
    input  logic [DATA_WIDTH-1:0]              m0_data_i,
    output logic [DATA_WIDTH-1:0]              m0_data_o,
    output logic                               m0_ack_o,
    output logic                               m0_err_o,
    input  logic                               m1_cyc_i,
    input  logic                               m1_stb_i,
    input  logic                               m1_we_i,
    input  logic [sel_width(DATA_WIDTH)-1:0]   m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]              m1_addr_i,
    input  logic [DATA_WIDTH-1:0]              m1_data_i,
    output logic [DATA_WIDTH-1:0]              m1_data_o,
    output logic                               m1_ack_o,
    output logic                               m1_err_o,
    output logic                               s_cyc_o,
    output logic                               s_stb_o,
    output logic                               s_we_o,
    output logic [sel_width(DATA_WIDTH)-1:0]   s_sel_o,
    output logic [ADDR_WIDTH-1:0]              s_addr_o,
    output logic [DATA_WIDTH-1:0]              s_data_o,
    input  logic [DATA_WIDTH-1:0]              s_data_i,
    input  logic                               s_ack_i,
    output logic [1:0]                         grant_o
);

    state_t state, state_next;
    logic   last_grant, last_grant_next;
    logic   gnt0, gnt1;
    logic   timeout_hit;

    wb_rr_arbiter2 u_rr (
        .req0       (m0_cyc_i & m0_stb_i),
        .req1       (m1_cyc_i & m1_stb_i),
        .last_grant (last_grant),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    // State and last-grant registers; reset makes m0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Slave-side mux and master-side return paths, decoded from state only.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_data_o = '0;
        m1_data_o = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        grant_o   = GNT_NONE;
        case (state)
            ST_GRANT0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                m0_data_o = s_data_i;
                m1_data_o = s_data_i;
                m0_ack_o  = s_ack_i;
                grant_o   = GNT_M0;
            end
            ST_GRANT1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                m0_data_o = s_data_i;
                m1_data_o = s_data_i;
                m1_ack_o  = s_ack_i;
                grant_o   = GNT_M1;
            end
            default: ;
        endcase
    end

    // Error pulse goes to the current owner in the cycle the timeout fires.
    assign m0_err_o = (state == ST_GRANT0) && timeout_hit;
    assign m1_err_o = (state == ST_GRANT1) && timeout_hit;

    // Next-state: arbitrate in IDLE, hold while owner keeps cyc, one ERR cycle.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            ST_IDLE: begin
                if (gnt0)      state_next = ST_GRANT0;
                else if (gnt1) state_next = ST_GRANT1;
            end
            ST_GRANT0: begin
                if (!m0_cyc_i) begin
                    state_next      = ST_IDLE;
                    last_grant_next = 1'b0;
                end else if (timeout_hit) begin
                    state_next      = ST_ERR;
                    last_grant_next = 1'b0;
                end
            end
            ST_GRANT1: begin
                if (!m1_cyc_i) begin
                    state_next      = ST_IDLE;
                    last_grant_next = 1'b1;
                end else if (timeout_hit) begin
                    state_next      = ST_ERR;
                    last_grant_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Ack timeout: counts strobe cycles without ack; an ack in the firing
    // cycle suppresses the error because ack is excluded from timeout_hit.
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
        logic [CW-1:0] cnt;

        // Saturating counter, cleared on ack, strobe drop or state change.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if ((state_next != state) || !s_stb_o || s_ack_i) begin
                cnt <= '0;
            end else if (cnt != {CW{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign timeout_hit = s_stb_o && !s_ack_i &&
                             (cnt == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter with an 8-cycle timeout.
module tb_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [SW-1:0] m0_sel_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_data_i, m0_data_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SW-1:0] m1_sel_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i, m1_data_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o, s_data_i;
    logic          s_ack_i;
    logic [1:0]    grant_o;

    int total = 0;
    int bad   = 0;

    wb_bus_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_sel_i  (m0_sel_i),
        .m0_addr_i (m0_addr_i),
        .m0_data_i (m0_data_i),
        .m0_data_o (m0_data_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_sel_i  (m1_sel_i),
        .m1_addr_i (m1_addr_i),
        .m1_data_i (m1_data_i),
        .m1_data_o (m1_data_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .grant_o   (grant_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then driven.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m0_drive(input logic cyc, input logic we, input logic [31:0] addr,
                            input logic [31:0] data);
        m0_cyc_i  = cyc;
        m0_stb_i  = cyc;
        m0_we_i   = we;
        m0_sel_i  = 4'hF;
        m0_addr_i = addr;
        m0_data_i = data;
    endtask

    task automatic m1_drive(input logic cyc, input logic we, input logic [31:0] addr,
                            input logic [31:0] data);
        m1_cyc_i  = cyc;
        m1_stb_i  = cyc;
        m1_we_i   = we;
        m1_sel_i  = 4'hF;
        m1_addr_i = addr;
        m1_data_i = data;
    endtask

    initial begin
        rst      = 1'b1;
        s_ack_i  = 1'b0;
        s_data_i = '0;
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        settle();
        chk("reset_cyc", {31'd0, s_cyc_o}, 32'd0);
        chk("reset_grant", {30'd0, grant_o}, 32'd0);
        step();
        rst = 1'b0;

        // 1: m0 read, ack two cycles after strobe
        m0_drive(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        settle();
        chk("t1_cyc_before_grant", {31'd0, s_cyc_o}, 32'd0);
        step();
        settle();
        chk("t1_cyc_rise", {31'd0, s_cyc_o}, 32'd1);
        chk("t1_addr", s_addr_o, 32'h0000_0100);
        chk("t1_grant", {30'd0, grant_o}, 32'd1);
        chk("t1_no_ack_yet", {31'd0, m0_ack_o}, 32'd0);
        step();
        step();
        s_ack_i  = 1'b1;
        s_data_i = 32'hDEAD_BEEF;
        settle();
        chk("t1_m0_ack", {31'd0, m0_ack_o}, 32'd1);
        chk("t1_m0_data", m0_data_o, 32'hDEAD_BEEF);
        chk("t1_m1_ack", {31'd0, m1_ack_o}, 32'd0);
        step();
        s_ack_i = 1'b0;
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        settle();
        chk("t1_release", {30'd0, grant_o}, 32'd0);

        // 2: tie right after reset goes to m0, then m1, then m0 again
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        step();
        settle();
        chk("t2_first_tie", {30'd0, grant_o}, 32'd1);
        step();
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("t2_hold_until_edge", {30'd0, grant_o}, 32'd1);
        step();
        settle();
        chk("t2_idle_gap", {30'd0, grant_o}, 32'd0);
        step();
        settle();
        chk("t2_m1_grant", {30'd0, grant_o}, 32'd2);
        chk("t2_m1_addr", s_addr_o, 32'h0000_0020);
        step();
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        m0_drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        settle();
        chk("t2_idle_before_tie", {30'd0, grant_o}, 32'd0);
        step();
        settle();
        chk("t2_second_tie", {30'd0, grant_o}, 32'd1);
        step();
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // 3: m0 locks the bus over three write beats while m1 waits
        m0_drive(1'b1, 1'b1, 32'h0000_0200, 32'h1);
        step();
        m1_drive(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        for (int b = 1; b <= 3; b++) begin
            m0_data_i = 32'(b);
            s_ack_i   = 1'b1;
            settle();
            chk("t3_grant_beat", {30'd0, grant_o}, 32'd1);
            chk("t3_wdata", s_data_o, 32'(b));
            chk("t3_we_sel", {27'd0, s_we_o, s_sel_o}, 32'h1F);
            chk("t3_m0_ack", {31'd0, m0_ack_o}, 32'd1);
            chk("t3_m1_ack", {31'd0, m1_ack_o}, 32'd0);
            step();
        end
        s_ack_i = 1'b0;
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("t3_still_m0", {30'd0, grant_o}, 32'd1);
        step();
        settle();
        chk("t3_idle_gap", {30'd0, grant_o}, 32'd0);
        step();

        // 4: m1 read never acked; error on the 8th strobe cycle
        settle();
        chk("t4_m1_grant", {30'd0, grant_o}, 32'd2);
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) m0_drive(1'b1, 1'b0, 32'h0000_0400, 32'h0);
            settle();
            chk("t4_no_err_early", {31'd0, m1_err_o}, 32'd0);
            step();
        end
        settle();
        chk("t4_err_8th", {31'd0, m1_err_o}, 32'd1);
        chk("t4_m0_no_err", {31'd0, m0_err_o}, 32'd0);
        chk("t4_cyc_during_err", {31'd0, s_cyc_o}, 32'd1);
        step();
        settle();
        chk("t4_err_state_cyc", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
        chk("t4_err_state_grant", {30'd0, grant_o}, 32'd0);
        chk("t4_err_pulse_over", {31'd0, m1_err_o}, 32'd0);
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        settle();
        chk("t4_idle", {30'd0, grant_o}, 32'd0);
        step();
        settle();
        chk("t4_m0_granted", {30'd0, grant_o}, 32'd1);
        chk("t4_m0_addr", s_addr_o, 32'h0000_0400);

        // 5: ack arrives on the 8th strobe cycle; ack wins over timeout
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h0000_0500, 32'h0);
        step();
        settle();
        chk("t5_idle", {30'd0, grant_o}, 32'd0);
        step();
        for (int c = 1; c <= 7; c++) begin
            step();
        end
        s_ack_i  = 1'b1;
        s_data_i = 32'hCAFE_0005;
        settle();
        chk("t5_m1_ack", {31'd0, m1_ack_o}, 32'd1);
        chk("t5_m1_no_err", {31'd0, m1_err_o}, 32'd0);
        chk("t5_m1_data", m1_data_o, 32'hCAFE_0005);
        step();
        s_ack_i = 1'b0;
        settle();
        chk("t5_no_err_state", {30'd0, grant_o}, 32'd2);
        chk("t5_cyc_held", {31'd0, s_cyc_o}, 32'd1);

        // 6: asynchronous reset mid-transaction
        step();
        #1;
        rst = 1'b1;
        settle();
        chk("t6_async_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
        chk("t6_async_grant", {30'd0, grant_o}, 32'd0);
        m1_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        m0_drive(1'b1, 1'b0, 32'h0000_0600, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h0000_0700, 32'h0);
        settle();
        chk("t6_idle_after_reset", {30'd0, grant_o}, 32'd0);
        step();
        settle();
        chk("t6_tie_to_m0", {30'd0, grant_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
